// File: rtl/debounce_multi_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module  : debounce_multi_if
// Brief   : Button bus between raw keypad inputs and the conditioned outputs.
// Revision: 1.0 - initial release
// ---------------------------------------------------------------------------
interface debounce_multi_if #(
  parameter int N_BTN = 4
);
  logic [N_BTN-1:0] BTN_IN;
  logic [N_BTN-1:0] BTN_LEVEL;
  logic [N_BTN-1:0] BTN_PRESS;
  logic [N_BTN-1:0] BTN_RELEASE;
  logic [N_BTN-1:0] BTN_REPEAT;
  logic             BTN_ANY;

  modport master (
    output BTN_IN,
    input  BTN_LEVEL, BTN_PRESS, BTN_RELEASE, BTN_REPEAT, BTN_ANY
  );

  modport slave (
    input  BTN_IN,
    output BTN_LEVEL, BTN_PRESS, BTN_RELEASE, BTN_REPEAT, BTN_ANY
  );
endinterface
`default_nettype wire

// File: rtl/debounce_multi.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module  : debounce_multi
// Brief   : Per-channel synchroniser, press/release debounce FSM and
//           hold/auto-repeat timer producing one-cycle strobes and a level.
// Revision: 1.0 - initial release
// ---------------------------------------------------------------------------
module debounce_multi #(
  parameter int N_BTN        = 4,
  parameter int DEBOUNCE_CYC = 1000000,
  parameter int HOLD_CYC     = 50000000,
  parameter int REPEAT_CYC   = 10000000,
  parameter bit REPEAT_EN    = 1'b1,
  parameter int DB_W         = 20,
  parameter int RP_W         = 26
) (
  input wire logic         CLK,
  input wire logic         RESET,
  debounce_multi_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE         = 2'd0,
    S_PRESS_WAIT   = 2'd1,
    S_HELD         = 2'd2,
    S_RELEASE_WAIT = 2'd3
  } state_t;

  // The sample that causes entry into a wait state counts as the first stable one.
  localparam logic [DB_W-1:0] c_DB_LOAD   = DB_W'(DEBOUNCE_CYC - 2);
  localparam logic [RP_W-1:0] c_HOLD_LOAD = RP_W'(HOLD_CYC - 1);
  localparam logic [RP_W-1:0] c_RPT_LOAD  = RP_W'(REPEAT_CYC - 1);

  logic [N_BTN-1:0] w_level;
  logic [N_BTN-1:0] w_press;
  logic [N_BTN-1:0] w_release;
  logic [N_BTN-1:0] w_repeat;

  for (genvar i = 0; i < N_BTN; i++) begin : g_ch
    logic            r_sync1;
    logic            r_sync2;
    state_t          r_state;
    state_t          w_next;
    logic [DB_W-1:0] r_dcnt;
    logic            w_dload;
    logic            w_press_ev;
    logic            w_rel_ev;
    logic            r_press_q;
    logic            r_rel_q;
    logic            r_press;
    logic            r_release;
    logic            r_level;

    always_comb begin
      w_next     = r_state;
      w_dload    = 1'b0;
      w_press_ev = 1'b0;
      w_rel_ev   = 1'b0;
      case (r_state)
        S_IDLE: begin
          if (r_sync2) begin
            w_next  = S_PRESS_WAIT;
            w_dload = 1'b1;
          end
        end
        S_PRESS_WAIT: begin
          if (!r_sync2) begin
            w_next = S_IDLE;
          end else if (r_dcnt == '0) begin
            w_next     = S_HELD;
            w_press_ev = 1'b1;
          end
        end
        S_HELD: begin
          if (!r_sync2) begin
            w_next  = S_RELEASE_WAIT;
            w_dload = 1'b1;
          end
        end
        S_RELEASE_WAIT: begin
          if (r_sync2) begin
            w_next = S_HELD;
          end else if (r_dcnt == '0) begin
            w_next   = S_IDLE;
            w_rel_ev = 1'b1;
          end
        end
        default: w_next = S_IDLE;
      endcase
    end

    // Strobes pass through one extra stage so press and level rise together.
    always_ff @(posedge CLK) begin
      if (RESET) begin
        r_sync1   <= 1'b0;
        r_sync2   <= 1'b0;
        r_state   <= S_IDLE;
        r_dcnt    <= '0;
        r_press_q <= 1'b0;
        r_rel_q   <= 1'b0;
        r_press   <= 1'b0;
        r_release <= 1'b0;
        r_level   <= 1'b0;
      end else begin
        r_sync1   <= bus.BTN_IN[i];
        r_sync2   <= r_sync1;
        r_state   <= w_next;
        if (w_dload) begin
          r_dcnt <= c_DB_LOAD;
        end else if (r_dcnt != '0) begin
          r_dcnt <= r_dcnt - DB_W'(1);
        end
        r_press_q <= w_press_ev;
        r_rel_q   <= w_rel_ev;
        r_press   <= r_press_q;
        r_release <= r_rel_q;
        r_level   <= (r_state == S_HELD) || (r_state == S_RELEASE_WAIT);
      end
    end

    assign w_level[i]   = r_level;
    assign w_press[i]   = r_press;
    assign w_release[i] = r_release;

    if (REPEAT_EN) begin : g_rep
      logic [RP_W-1:0] r_rcnt;
      logic            w_rep_ev;
      logic            r_rep_q;
      logic            r_repeat;

      assign w_rep_ev = (r_state == S_HELD) && (r_rcnt == '0);

      // Counts only while HELD, so a release bounce pauses rather than restarts it.
      always_ff @(posedge CLK) begin
        if (RESET) begin
          r_rcnt   <= '0;
          r_rep_q  <= 1'b0;
          r_repeat <= 1'b0;
        end else begin
          r_rep_q  <= w_rep_ev;
          r_repeat <= r_rep_q;
          if (w_press_ev) begin
            r_rcnt <= c_HOLD_LOAD;
          end else if (w_rel_ev) begin
            r_rcnt <= '0;
          end else if (r_state == S_HELD) begin
            r_rcnt <= w_rep_ev ? c_RPT_LOAD : (r_rcnt - RP_W'(1));
          end
        end
      end

      assign w_repeat[i] = r_repeat;
    end else begin : g_norep
      assign w_repeat[i] = 1'b0;
    end
  end

  assign bus.BTN_LEVEL   = w_level;
  assign bus.BTN_PRESS   = w_press;
  assign bus.BTN_RELEASE = w_release;
  assign bus.BTN_REPEAT  = w_repeat;
  assign bus.BTN_ANY     = |(w_press | w_repeat);

endmodule
`default_nettype wire

// File: tb/tb_debounce_multi.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module  : tb_debounce_multi
// Brief   : Directed, table-driven bench for debounce_multi (repeat on and off).
// Revision: 1.0 - initial release
// ---------------------------------------------------------------------------
module tb_debounce_multi;
  localparam int NB   = 4;
  localparam int DB   = 4;
  localparam int HD   = 10;
  localparam int RP   = 3;
  localparam int MAXC = 64;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [NB-1:0] btn = '0;

  always #5 clk = ~clk;

  debounce_multi_if #(.N_BTN(NB)) bus_r ();
  debounce_multi_if #(.N_BTN(NB)) bus_n ();
  assign bus_r.BTN_IN = btn;
  assign bus_n.BTN_IN = btn;

  debounce_multi #(
    .N_BTN(NB), .DEBOUNCE_CYC(DB), .HOLD_CYC(HD), .REPEAT_CYC(RP),
    .REPEAT_EN(1'b1), .DB_W(20), .RP_W(26)
  ) u_dut (
    .CLK(clk), .RESET(rst), .bus(bus_r)
  );

  debounce_multi #(
    .N_BTN(NB), .DEBOUNCE_CYC(DB), .HOLD_CYC(HD), .REPEAT_CYC(RP),
    .REPEAT_EN(1'b0), .DB_W(20), .RP_W(26)
  ) u_dut_norep (
    .CLK(clk), .RESET(rst), .bus(bus_n)
  );

  // Entry k: inputs applied before edge k; expectations seen just after edge k.
  logic [NB-1:0] pat  [MAXC];
  logic          rpat [MAXC];
  logic [NB-1:0] e_pr [MAXC];
  logic [NB-1:0] e_rl [MAXC];
  logic [NB-1:0] e_rp [MAXC];
  logic [NB-1:0] lvl = '0;
  int            n_cmp = 0;
  int            n_bad = 0;

  typedef struct {
    int ch;
    int len;
    bit acc;
  } pulse_t;

  pulse_t tv [8];

  task automatic clear_scn();
    for (int k = 0; k < MAXC; k++) begin
      pat[k]  = '0;
      rpat[k] = 1'b0;
      e_pr[k] = '0;
      e_rl[k] = '0;
      e_rp[k] = '0;
    end
  endtask

  task automatic hi(input int ch, input int from, input int len);
    for (int k = from; k < from + len; k++) pat[k][ch] = 1'b1;
  endtask

  task automatic chk(input string scn, input string nm, input int k,
                     input logic [NB-1:0] act, input logic [NB-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s.%s at edge %0d: got %b, expected %b", scn, nm, k, act, exp);
    end
  endtask

  task automatic run(input string scn, input int n);
    logic [NB-1:0] ex_any;
    logic [NB-1:0] ex_any_n;
    for (int k = 0; k < n; k++) begin
      btn = pat[k];
      rst = rpat[k];
      @(posedge clk);
      #1;
      lvl      = rpat[k] ? '0 : ((lvl | e_pr[k]) & ~e_rl[k]);
      ex_any   = {{(NB-1){1'b0}}, |(e_pr[k] | e_rp[k])};
      ex_any_n = {{(NB-1){1'b0}}, |e_pr[k]};
      chk(scn, "press",     k, bus_r.BTN_PRESS,   e_pr[k]);
      chk(scn, "release",   k, bus_r.BTN_RELEASE, e_rl[k]);
      chk(scn, "repeat",    k, bus_r.BTN_REPEAT,  e_rp[k]);
      chk(scn, "level",     k, bus_r.BTN_LEVEL,   lvl);
      chk(scn, "any",       k, {{(NB-1){1'b0}}, bus_r.BTN_ANY}, ex_any);
      chk(scn, "nr.press",  k, bus_n.BTN_PRESS,   e_pr[k]);
      chk(scn, "nr.release",k, bus_n.BTN_RELEASE, e_rl[k]);
      chk(scn, "nr.repeat", k, bus_n.BTN_REPEAT,  '0);
      chk(scn, "nr.level",  k, bus_n.BTN_LEVEL,   lvl);
      chk(scn, "nr.any",    k, {{(NB-1){1'b0}}, bus_n.BTN_ANY}, ex_any_n);
    end
    rst = 1'b0;
  endtask

  initial begin
    tv[0] = '{1, 1, 1'b0};
    tv[1] = '{1, 2, 1'b0};
    tv[2] = '{1, 3, 1'b0};
    tv[3] = '{1, 4, 1'b1};
    tv[4] = '{2, 5, 1'b1};
    tv[5] = '{3, 8, 1'b1};
    tv[6] = '{0, 12, 1'b1};
    tv[7] = '{2, 3, 1'b0};

    clear_scn();
    for (int k = 0; k < 3; k++) rpat[k] = 1'b1;
    run("reset", 5);

    // Clean press held 30 cycles: press at 6, repeats every 3 from 16, release at 36.
    clear_scn();
    hi(0, 0, 30);
    e_pr[6][0]  = 1'b1;
    e_rl[36][0] = 1'b1;
    for (int k = 16; k <= 31; k += 3) e_rp[k][0] = 1'b1;
    run("clean", 44);

    clear_scn();
    hi(1, 0, 3);
    hi(1, 4, 2);
    hi(1, 7, 3);
    run("bounce", 20);

    for (int t = 0; t < 8; t++) begin
      clear_scn();
      hi(tv[t].ch, 0, tv[t].len);
      if (tv[t].acc) begin
        e_pr[6][tv[t].ch]             = 1'b1;
        e_rl[tv[t].len + 6][tv[t].ch] = 1'b1;
      end
      run($sformatf("pulse%0d_len%0d", t, tv[t].len), tv[t].len + 10);
    end

    clear_scn();
    hi(0, 0, 8);
    hi(0, 10, 1);
    e_pr[6][0]  = 1'b1;
    e_rl[17][0] = 1'b1;
    run("relbounce", 22);

    // Timer freezes during the 2-cycle dip, so the first repeat lands late at 18.
    clear_scn();
    hi(0, 0, 8);
    hi(0, 10, 6);
    e_pr[6][0]  = 1'b1;
    e_rp[18][0] = 1'b1;
    e_rl[22][0] = 1'b1;
    run("resume", 27);

    clear_scn();
    hi(1, 0, 8);
    hi(3, 0, 20);
    e_pr[6][1]  = 1'b1;
    e_pr[6][3]  = 1'b1;
    e_rl[14][1] = 1'b1;
    e_rl[26][3] = 1'b1;
    e_rp[16][3] = 1'b1;
    e_rp[19][3] = 1'b1;
    e_rp[22][3] = 1'b1;
    run("concur", 32);

    clear_scn();
    hi(2, 0, 20);
    hi(0, 4, 16);
    rpat[8]     = 1'b1;
    e_pr[6][2]  = 1'b1;
    e_pr[15][0] = 1'b1;
    e_pr[15][2] = 1'b1;
    e_rl[26][0] = 1'b1;
    e_rl[26][2] = 1'b1;
    run("midreset", 30);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
`default_nettype wire
